// File: rtl/daq_ctrl_if.sv
// AXI4-Lite register-bus bundle for daq_ctrl.
// The slave modport is the DAQ side; master is the processor/bench side.
interface daq_ctrl_if;
  logic [31:0] s00_axi_awaddr;
  logic        s00_axi_awvalid;
  logic        s00_axi_awready;
  logic [31:0] s00_axi_wdata;
  logic [3:0]  s00_axi_wstrb;
  logic        s00_axi_wvalid;
  logic        s00_axi_wready;
  logic [1:0]  s00_axi_bresp;
  logic        s00_axi_bvalid;
  logic        s00_axi_bready;
  logic [31:0] s00_axi_araddr;
  logic        s00_axi_arvalid;
  logic        s00_axi_arready;
  logic [31:0] s00_axi_rdata;
  logic [1:0]  s00_axi_rresp;
  logic        s00_axi_rvalid;
  logic        s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awvalid, s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
           s00_axi_bready, s00_axi_araddr, s00_axi_arvalid, s00_axi_rready,
    output s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
           s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awvalid, s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
           s00_axi_bready, s00_axi_araddr, s00_axi_arvalid, s00_axi_rready,
    input  s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
           s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
  );
endinterface

// File: rtl/daq_ctrl.sv
// Two-channel pulse counter with AXI4-Lite control/readout.
// Define DAQ_LIVE_CNT_EN to expose the running counters at 0x10/0x14.
//
// state  | meaning
// W_IDLE | waiting for awvalid & wvalid
// W_ACK  | awready/wready high, register write on this edge
// W_RESP | bvalid held until bready
// R_IDLE | waiting for arvalid
// R_ACK  | arready high, rdata captured on this edge
// R_DATA | rvalid held until rready
module daq_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic      s00_axi_aclk,
  input  logic      s00_axi_areset,
  daq_ctrl_if.slave axi,
  input  logic      I_PROC,
  input  logic      I_ARM,
  input  logic      I_SEL,
  input  logic      I_A0,
  input  logic      I_A1,
  input  logic      I_Z0,
  input  logic      I_Z1,
  output logic      O_ARM,
  output logic      O_SEL,
  output logic      O_A0,
  output logic      O_A1,
  output logic      O_Z0,
  output logic      O_Z1,
  output logic      O_READY_0,
  output logic      O_READY_1,
  output logic      O_OVERFLOW_0,
  output logic      O_OVERFLOW_1
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

  wr_state_t w_state_q, w_state_d;
  rd_state_t r_state_q, r_state_d;

  // pin order: arm, sel, a0, a1, z0, z1
  logic [5:0] sync1_q, sync2_q, dly_q;
  logic [5:0] rise;
  logic       arm_dly_q, arm_rise;

  logic [1:0]            ctrl_q, ctrl_d;
  logic [1:0]            rdy_q, rdy_d, ovf_q, ovf_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d, res_q, res_d;
  logic [CNT_W-1:0]      base_v, inc_v;
  logic [31:0]           rdata_q, rdata_d;
  logic                  we, clr;
  logic [2:0]            waddr, raddr;
  logic [1:0]            a_rise, z_rise;

  assign rise   = sync2_q & ~dly_q;
  assign a_rise = rise[3:2];
  assign z_rise = rise[5:4];

  assign O_ARM = I_PROC ? ctrl_q[0] : sync2_q[0];
  assign O_SEL = I_PROC ? ctrl_q[1] : sync2_q[1];
  assign {O_Z1, O_Z0, O_A1, O_A0} = sync2_q[5:2];
  assign {O_READY_1, O_READY_0}       = rdy_q;
  assign {O_OVERFLOW_1, O_OVERFLOW_0} = ovf_q;
  assign arm_rise = O_ARM & ~arm_dly_q;

  assign waddr = axi.s00_axi_awaddr[4:2];
  assign raddr = axi.s00_axi_araddr[4:2];
  assign we    = (w_state_q == W_ACK) & axi.s00_axi_awvalid & axi.s00_axi_wvalid;
  assign clr   = we & (waddr == 3'd0) & axi.s00_axi_wstrb[0] & axi.s00_axi_wdata[2];

  assign axi.s00_axi_awready = (w_state_q == W_ACK);
  assign axi.s00_axi_wready  = (w_state_q == W_ACK);
  assign axi.s00_axi_bvalid  = (w_state_q == W_RESP);
  assign axi.s00_axi_bresp   = 2'b00;
  assign axi.s00_axi_arready = (r_state_q == R_ACK);
  assign axi.s00_axi_rvalid  = (r_state_q == R_DATA);
  assign axi.s00_axi_rresp   = 2'b00;
  assign axi.s00_axi_rdata   = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{axi.s00_axi_awaddr[31:5], axi.s00_axi_awaddr[1:0],
                         axi.s00_axi_araddr[31:5], axi.s00_axi_araddr[1:0],
                         axi.s00_axi_wdata[31:4], axi.s00_axi_wstrb[3:1]};

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: if (axi.s00_axi_awvalid && axi.s00_axi_wvalid) w_state_d = W_ACK;
      W_ACK:  w_state_d = we ? W_RESP : W_IDLE;
      W_RESP: if (axi.s00_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (axi.s00_axi_arvalid) r_state_d = R_ACK;
      R_ACK: begin
        if (axi.s00_axi_arvalid) begin
          r_state_d = R_DATA;
          case (raddr)
            3'd0:    rdata_d = {30'd0, ctrl_q};
            3'd1:    rdata_d = {28'd0, ovf_q, rdy_q};
            3'd2:    rdata_d = 32'(res_q[0]);
            3'd3:    rdata_d = 32'(res_q[1]);
`ifdef DAQ_LIVE_CNT_EN
            3'd4:    rdata_d = 32'(cnt_q[0]);
            3'd5:    rdata_d = 32'(cnt_q[1]);
`endif
            default: rdata_d = 32'd0;
          endcase
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: if (axi.s00_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // W1C is applied first so a same-cycle set event overrides it
  always_comb begin
    ctrl_d = ctrl_q;
    rdy_d  = rdy_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    base_v = '0;
    inc_v  = '0;
    if (we && waddr == 3'd0 && axi.s00_axi_wstrb[0]) ctrl_d = axi.s00_axi_wdata[1:0];
    if (we && waddr == 3'd1 && axi.s00_axi_wstrb[0]) begin
      rdy_d = rdy_q & ~axi.s00_axi_wdata[1:0];
      ovf_d = ovf_q & ~axi.s00_axi_wdata[3:2];
    end
    for (int ch = 0; ch < 2; ch++) begin
      base_v = arm_rise ? '0 : cnt_q[ch];
      if (arm_rise) cnt_d[ch] = '0;
      if (O_ARM) begin
        inc_v = base_v;
        if (a_rise[ch]) begin
          if (base_v == CNT_MAX) ovf_d[ch] = 1'b1;
          else                   inc_v = base_v + 1'b1;
        end
        if (z_rise[ch]) begin
          res_d[ch] = inc_v;
          cnt_d[ch] = '0;
          rdy_d[ch] = 1'b1;
        end else begin
          cnt_d[ch] = inc_v;
        end
      end
    end
    if (clr) begin
      cnt_d = '0;
      res_d = '0;
      rdy_d = '0;
      ovf_d = '0;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      dly_q     <= '0;
      arm_dly_q <= 1'b0;
      ctrl_q    <= '0;
      rdy_q     <= '0;
      ovf_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      sync1_q   <= {I_Z1, I_Z0, I_A1, I_A0, I_SEL, I_ARM};
      sync2_q   <= sync1_q;
      dly_q     <= sync2_q;
      arm_dly_q <= O_ARM;
      ctrl_q    <= ctrl_d;
      rdy_q     <= rdy_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule

// File: tb/tb_daq_ctrl.sv
// Directed bench for daq_ctrl built with CNT_W=4 so saturation is reachable.
// Expected LIVE0 values follow DAQ_LIVE_CNT_EN.
module tb_daq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  daq_ctrl_if axi();

  logic       i_proc = 1'b0, i_arm = 1'b0, i_sel = 1'b0;
  logic [3:0] ap = 4'b0000;  // {z1, z0, a1, a0}
  logic o_arm, o_sel, o_a0, o_a1, o_z0, o_z1;
  logic o_rdy0, o_rdy1, o_ovf0, o_ovf1;

  daq_ctrl #(.CNT_W(4)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst), .axi(axi),
    .I_PROC(i_proc), .I_ARM(i_arm), .I_SEL(i_sel),
    .I_A0(ap[0]), .I_A1(ap[1]), .I_Z0(ap[2]), .I_Z1(ap[3]),
    .O_ARM(o_arm), .O_SEL(o_sel), .O_A0(o_a0), .O_A1(o_a1), .O_Z0(o_z0), .O_Z1(o_z1),
    .O_READY_0(o_rdy0), .O_READY_1(o_rdy1), .O_OVERFLOW_0(o_ovf0), .O_OVERFLOW_1(o_ovf1)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic ok;
    @(negedge clk);
    axi.s00_axi_awaddr  = addr;
    axi.s00_axi_wdata   = data;
    axi.s00_axi_wstrb   = strb;
    axi.s00_axi_awvalid = 1'b1;
    axi.s00_axi_wvalid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.s00_axi_awready && axi.s00_axi_wready) begin ok = 1'b1; break; end
    end
    chk("wr_ready", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wvalid  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.s00_axi_bvalid) begin ok = 1'b1; break; end
    end
    chk("wr_bvalid", {31'd0, ok}, 32'd1);
    chk("bresp", {30'd0, axi.s00_axi_bresp}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data);
    logic ok;
    @(negedge clk);
    axi.s00_axi_araddr  = addr;
    axi.s00_axi_arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.s00_axi_arready) begin ok = 1'b1; break; end
    end
    chk("rd_ready", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    axi.s00_axi_arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.s00_axi_rvalid) begin ok = 1'b1; break; end
    end
    chk("rd_rvalid", {31'd0, ok}, 32'd1);
    chk("rresp", {30'd0, axi.s00_axi_rresp}, 32'd0);
    data = axi.s00_axi_rdata;
    axi.s00_axi_rready = 1'b1;
    @(posedge clk);
    #1;
    axi.s00_axi_rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_rd(addr, d);
    chk(tag, d, exp);
  endtask

  task automatic pulse(input logic [3:0] mask);
    @(negedge clk);
    ap = ap | mask;
    repeat (3) @(negedge clk);
    ap = ap & ~mask;
    repeat (3) @(negedge clk);
  endtask

  task automatic settle();
    repeat (5) @(negedge clk);
  endtask

  logic [31:0] live_pre_exp;

  initial begin
    axi.s00_axi_awaddr  = '0; axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wdata   = '0; axi.s00_axi_wstrb   = '0; axi.s00_axi_wvalid = 1'b0;
    axi.s00_axi_bready  = 1'b1;
    axi.s00_axi_araddr  = '0; axi.s00_axi_arvalid = 1'b0; axi.s00_axi_rready = 1'b0;

`ifdef DAQ_LIVE_CNT_EN
    live_pre_exp = 32'd2;
`else
    live_pre_exp = 32'd0;
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pins", {22'd0, o_arm, o_sel, o_a0, o_a1, o_z0, o_z1, o_rdy0, o_rdy1, o_ovf0, o_ovf1}, 32'd0);
    chk("rst_hs", {27'd0, axi.s00_axi_awready, axi.s00_axi_wready, axi.s00_axi_bvalid,
                   axi.s00_axi_arready, axi.s00_axi_rvalid}, 32'd0);
    chk("rst_rdata", axi.s00_axi_rdata, 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 6; a++) rd_chk("rst_reg", 32'(a * 4), 32'd0);

    // pin mode, both channels: 3 A then Z; first pulse also checks 2-cycle pin latency
    i_arm = 1'b1;
    settle();
    chk("arm_pin", {31'd0, o_arm}, 32'd1);
    @(negedge clk);
    ap = 4'b0011;
    @(posedge clk); #1;
    chk("a_lat1", {30'd0, o_a1, o_a0}, 32'd0);
    @(posedge clk); #1;
    chk("a_lat2", {30'd0, o_a1, o_a0}, 32'd3);
    repeat (2) @(negedge clk);
    ap = 4'b0000;
    repeat (3) @(negedge clk);
    pulse(4'b0011);
    pulse(4'b0011);
    pulse(4'b1100);
    settle();
    rd_chk("result0", 32'h08, 32'd3);
    rd_chk("result1", 32'h0C, 32'd3);
    chk("ready_pins", {30'd0, o_rdy1, o_rdy0}, 32'd3);
    rd_chk("status_rdy", 32'h04, 32'd3);
    axi_wr(32'h04, 32'h1, 4'hF);
    chk("w1c_rdy0", {30'd0, o_rdy1, o_rdy0}, 32'd2);
    axi_wr(32'h04, 32'h2, 4'h0);
    rd_chk("status_nostrb", 32'h04, 32'd2);

    // disarmed burst is ignored; re-arm clears and counts afresh
    i_arm = 1'b0;
    settle();
    pulse(4'b0011);
    pulse(4'b0010);
    pulse(4'b1100);
    settle();
    rd_chk("disarm_res0", 32'h08, 32'd3);
    rd_chk("disarm_res1", 32'h0C, 32'd3);
    rd_chk("disarm_stat", 32'h04, 32'd2);
    i_arm = 1'b1;
    settle();
    pulse(4'b0010);
    pulse(4'b1000);
    settle();
    rd_chk("rearm_res1", 32'h0C, 32'd1);
    axi_wr(32'h04, 32'h3, 4'hF);
    rd_chk("status_clr", 32'h04, 32'd0);

    // register control of arm/select
    i_arm = 1'b0;
    i_sel = 1'b0;
    i_proc = 1'b1;
    axi_wr(32'h00, 32'h3, 4'hF);
    chk("proc_armsel", {30'd0, o_arm, o_sel}, 32'd3);
    rd_chk("ctrl_rd", 32'h00, 32'd3);
    axi_wr(32'h00, 32'h0, 4'hF);
    chk("proc_off", {30'd0, o_arm, o_sel}, 32'd0);

    // saturation: 16 edges on a 4-bit counter
    axi_wr(32'h00, 32'h1, 4'hF);
    for (int k = 0; k < 16; k++) pulse(4'b0001);
    pulse(4'b0100);
    settle();
    rd_chk("ovf_status", 32'h04, 32'd5);
    chk("ovf_pin", {31'd0, o_ovf0}, 32'd1);
    rd_chk("ovf_result", 32'h08, 32'd15);

    // CLR zeroes results and flags but keeps ARM
    axi_wr(32'h00, 32'h5, 4'hF);
    rd_chk("clr_status", 32'h04, 32'd0);
    rd_chk("clr_res0", 32'h08, 32'd0);
    rd_chk("clr_res1", 32'h0C, 32'd0);
    rd_chk("clr_ctrl", 32'h00, 32'd1);
    chk("clr_ovf_pin", {31'd0, o_ovf0}, 32'd0);

    // coincident A and Z after two A edges
    pulse(4'b0001);
    pulse(4'b0001);
    settle();
    rd_chk("live_pre", 32'h10, live_pre_exp);
    pulse(4'b0101);
    settle();
    rd_chk("coinc_res0", 32'h08, 32'd3);
    rd_chk("live_post", 32'h10, 32'd0);
    rd_chk("coinc_stat", 32'h04, 32'd1);

    // unmapped space
    rd_chk("unmapped_rd", 32'h18, 32'd0);
    axi_wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped_wr_stat", 32'h04, 32'd1);
    rd_chk("unmapped_wr_ctrl", 32'h00, 32'd1);

    // reset mid-measurement
    pulse(4'b0001);
    pulse(4'b0001);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle();
    rd_chk("rst2_res0", 32'h08, 32'd0);
    rd_chk("rst2_live0", 32'h10, 32'd0);
    rd_chk("rst2_ctrl", 32'h00, 32'd0);
    chk("rst2_arm", {31'd0, o_arm}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
